// File: rtl/mopshub_bus_test_sequencer.sv
// MOPSHUB bus test sequencer: walks buses 0..last through RX / TX / custom
// message phases, guards every wait with an optional timeout, optionally
// repeats the sweep, and keeps pass/fail bookkeeping per run.
module mopshub_bus_test_sequencer #(
   parameter int N_BUSES    = 16,
   parameter int BUS_ID_W   = 5,
   parameter int TMO_W      = 16,
   parameter int GAP_CYCLES = 120,
   parameter int CNT_W      = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [BUS_ID_W-1:0] n_buses,
   input  logic [1:0]          mode,
   input  logic                loop_en,
   input  logic [CNT_W-1:0]    loop_count,
   input  logic [TMO_W-1:0]    timeout_cycles,
   input  logic                test_rx_end,
   input  logic                test_tx_end,
   input  logic                costum_msg_end,
   output logic                test_rx,
   output logic                test_tx,
   output logic                test_advanced,
   output logic                endwait_all,
   output logic [BUS_ID_W-1:0] bus_sel,
   output logic                busy,
   output logic                done,
   output logic [CNT_W-1:0]    pass_cnt,
   output logic [CNT_W-1:0]    fail_cnt,
   output logic [N_BUSES-1:0]  fail_mask,
   output logic [CNT_W-1:0]    iter_cnt
);

   typedef enum logic [2:0] {
      S_IDLE, S_RX_WAIT, S_ENDWAIT, S_GAP, S_TX_WAIT, S_ADV_WAIT, S_NEXT_BUS, S_DONE
   } state_t;

   localparam int                  GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0]    GAP_LAST = GAP_W'(GAP_CYCLES - 1);
   localparam logic [BUS_ID_W-1:0] MAX_BUS  = BUS_ID_W'(N_BUSES - 1);
   localparam logic [CNT_W-1:0]    CNT_MAX  = '1;

   state_t              state, state_n, first_phase;
   logic [TMO_W-1:0]    timer;
   logic [GAP_W-1:0]    gap_cnt;
   logic [BUS_ID_W-1:0] last_bus;
   logic                bus_failed;
   logic                launch, mark_fail, account;
   logic                tmo_hit, at_last, more_sweeps;

   // TX-only runs skip straight to the TX phase; every other mode opens with RX
   assign first_phase = (mode == 2'b01) ? S_TX_WAIT : S_RX_WAIT;
   // timer counts from 0 on the first wait cycle, so the wait lasts timeout_cycles
   assign tmo_hit     = (timeout_cycles != '0) && (timer == timeout_cycles - TMO_W'(1));
   assign at_last     = (bus_sel >= last_bus);
   // iter_cnt has not yet been bumped for the sweep that is finishing now
   assign more_sweeps = loop_en && ((loop_count == '0) ||
                        (({1'b0, iter_cnt} + (CNT_W+1)'(1)) < {1'b0, loop_count}));

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   // next-state logic; end pulses beat a same-cycle timeout, abort beats everything
   always_comb begin
      state_n   = state;
      launch    = 1'b0;
      mark_fail = 1'b0;
      account   = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_n = first_phase;
               launch  = 1'b1;
            end
         end
         S_RX_WAIT: begin
            if (test_rx_end)  state_n = (mode == 2'b00) ? S_NEXT_BUS : S_ENDWAIT;
            else if (tmo_hit) begin
               state_n   = S_NEXT_BUS;
               mark_fail = 1'b1;
            end
         end
         S_ENDWAIT: state_n = S_GAP;
         S_GAP: begin
            if (gap_cnt == GAP_LAST) state_n = S_TX_WAIT;
         end
         S_TX_WAIT: begin
            if (test_tx_end)  state_n = (mode == 2'b11) ? S_ADV_WAIT : S_NEXT_BUS;
            else if (tmo_hit) begin
               state_n   = S_NEXT_BUS;
               mark_fail = 1'b1;
            end
         end
         S_ADV_WAIT: begin
            if (costum_msg_end) state_n = S_NEXT_BUS;
            else if (tmo_hit) begin
               state_n   = S_NEXT_BUS;
               mark_fail = 1'b1;
            end
         end
         S_NEXT_BUS: begin
            account = 1'b1;
            state_n = (!at_last || more_sweeps) ? first_phase : S_DONE;
         end
         default: state_n = S_IDLE;
      endcase
      if (abort) begin
         state_n   = S_IDLE;
         launch    = 1'b0;
         mark_fail = 1'b0;
         account   = 1'b0;
      end
   end

   // phase timer and inter-phase gap counter
   always_ff @(posedge clk) begin
      if (rst) begin
         timer   <= '0;
         gap_cnt <= '0;
      end else begin
         if (state_n != state) timer <= '0;
         else if (state == S_RX_WAIT || state == S_TX_WAIT || state == S_ADV_WAIT)
            timer <= timer + TMO_W'(1);
         gap_cnt <= (state == S_GAP && state_n == S_GAP) ? gap_cnt + GAP_W'(1) : '0;
      end
   end

   // bus walk, bookkeeping counters and failure flags
   always_ff @(posedge clk) begin
      if (rst) begin
         bus_sel    <= '0;
         last_bus   <= '0;
         bus_failed <= 1'b0;
         pass_cnt   <= '0;
         fail_cnt   <= '0;
         fail_mask  <= '0;
         iter_cnt   <= '0;
      end else if (launch) begin
         bus_sel    <= '0;
         last_bus   <= (n_buses > MAX_BUS) ? MAX_BUS : n_buses;
         bus_failed <= 1'b0;
         pass_cnt   <= '0;
         fail_cnt   <= '0;
         fail_mask  <= '0;
         iter_cnt   <= '0;
      end else if (mark_fail) begin
         bus_failed <= 1'b1;
      end else if (account) begin
         bus_failed <= 1'b0;
         if (bus_failed) begin
            if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_W'(1);
            for (int i = 0; i < N_BUSES; i++)
               if (bus_sel == BUS_ID_W'(i)) fail_mask[i] <= 1'b1;
         end else if (pass_cnt != CNT_MAX) begin
            pass_cnt <= pass_cnt + CNT_W'(1);
         end
         if (!at_last) begin
            bus_sel <= bus_sel + BUS_ID_W'(1);
         end else begin
            if (iter_cnt != CNT_MAX) iter_cnt <= iter_cnt + CNT_W'(1);
            if (more_sweeps) bus_sel <= '0;
         end
      end
   end

   // registered handshake/status outputs decoded from the upcoming state
   always_ff @(posedge clk) begin
      if (rst) begin
         test_rx       <= 1'b0;
         test_tx       <= 1'b0;
         test_advanced <= 1'b0;
         endwait_all   <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         test_rx       <= (state_n == S_RX_WAIT);
         test_tx       <= (state_n == S_TX_WAIT);
         test_advanced <= (state_n == S_ADV_WAIT);
         endwait_all   <= (state_n == S_ENDWAIT);
         busy          <= (state_n != S_IDLE) && (state_n != S_DONE);
         done          <= (state_n == S_DONE) && (state != S_DONE);
      end
   end

endmodule

// File: tb/tb_mopshub_bus_test_sequencer.sv
// Bench for mopshub_bus_test_sequencer: a responder answers each request after
// a per-phase/per-bus delay, and a queue-based model predicts the request log
// and final bookkeeping for directed and random runs.
module tb_mopshub_bus_test_sequencer;
   localparam int N_BUSES    = 16;
   localparam int BUS_ID_W   = 5;
   localparam int TMO_W      = 16;
   localparam int GAP_CYCLES = 120;
   localparam int CNT_W      = 16;
   localparam int NEVER      = 1000000;

   logic                clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, loop_en = 1'b0;
   logic [BUS_ID_W-1:0] n_buses = '0;
   logic [1:0]          mode = '0;
   logic [CNT_W-1:0]    loop_count = '0;
   logic [TMO_W-1:0]    timeout_cycles = '0;
   logic                test_rx_end = 1'b0, test_tx_end = 1'b0, costum_msg_end = 1'b0;
   logic                test_rx, test_tx, test_advanced, endwait_all, busy, done;
   logic [BUS_ID_W-1:0] bus_sel;
   logic [CNT_W-1:0]    pass_cnt, fail_cnt, iter_cnt;
   logic [N_BUSES-1:0]  fail_mask;

   always #5 clk = ~clk;

   mopshub_bus_test_sequencer #(
      .N_BUSES(N_BUSES), .BUS_ID_W(BUS_ID_W), .TMO_W(TMO_W),
      .GAP_CYCLES(GAP_CYCLES), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .n_buses(n_buses),
      .mode(mode), .loop_en(loop_en), .loop_count(loop_count),
      .timeout_cycles(timeout_cycles), .test_rx_end(test_rx_end),
      .test_tx_end(test_tx_end), .costum_msg_end(costum_msg_end),
      .test_rx(test_rx), .test_tx(test_tx), .test_advanced(test_advanced),
      .endwait_all(endwait_all), .bus_sel(bus_sel), .busy(busy), .done(done),
      .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .fail_mask(fail_mask),
      .iter_cnt(iter_cnt)
   );

   // event log: ph 0=rx request, 1=tx request, 2=custom request, 3=endwait pulse
   typedef struct {int ph; int bus; int cyc;} ev_t;
   ev_t ev_q[$];
   int  exp_q[$];
   int  dly[3][32];
   int  n_assert = 0, n_fail = 0, done_cnt = 0, cyc = 0;
   bit  spur_en = 1'b0;
   int  exp_pass, exp_fail, exp_iter;
   logic [N_BUSES-1:0] exp_mask;
   bit   act = 1'b0;
   int   aph = 0, tgt = 0, cnt = 0;
   logic p_rx = 1'b0, p_tx = 1'b0, p_adv = 1'b0;

   function automatic logic req_of(input int p);
      case (p)
         0:       return test_rx;
         1:       return test_tx;
         default: return test_advanced;
      endcase
   endfunction

   task automatic pulse(input int p);
      case (p)
         0:       test_rx_end = 1'b1;
         1:       test_tx_end = 1'b1;
         default: costum_msg_end = 1'b1;
      endcase
   endtask

   task automatic begin_phase(input int p);
      ev_q.push_back('{p, int'(bus_sel), cyc});
      act = 1'b1; aph = p; tgt = dly[p][bus_sel]; cnt = 0;
   endtask

   // responder + monitor: answers requests after dly cycles (cycle 0 = first request cycle)
   always @(posedge clk) begin
      #1;
      cyc++;
      test_rx_end = 1'b0; test_tx_end = 1'b0; costum_msg_end = 1'b0;
      if (act && !req_of(aph)) act = 1'b0;
      if (test_rx && !p_rx)       begin_phase(0);
      if (test_tx && !p_tx)       begin_phase(1);
      if (test_advanced && !p_adv) begin_phase(2);
      if (endwait_all) ev_q.push_back('{3, int'(bus_sel), cyc});
      if (spur_en)
         for (int p = 0; p < 3; p++)
            if (!req_of(p) && $urandom_range(0, 7) == 0) pulse(p);
      if (act) begin
         if (cnt == tgt) begin pulse(aph); act = 1'b0; end
         cnt++;
      end
      if (done) done_cnt++;
      p_rx = test_rx; p_tx = test_tx; p_adv = test_advanced;
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // reference: walk buses/phases, a phase passes iff its answer lands before the timeout
   task automatic model(input int md, input int nb, input int tmo, input int le, input int lc);
      int last, iters;
      int phs[$];
      bit failed, ok;
      exp_q.delete();
      exp_pass = 0; exp_fail = 0; exp_iter = 0; exp_mask = '0;
      last  = (nb > N_BUSES - 1) ? N_BUSES - 1 : nb;
      iters = le ? lc : 1;
      case (md)
         0:       phs = '{0};
         1:       phs = '{1};
         2:       phs = '{0, 1};
         default: phs = '{0, 1, 2};
      endcase
      for (int it = 0; it < iters; it++) begin
         for (int b = 0; b <= last; b++) begin
            failed = 1'b0;
            foreach (phs[k]) if (!failed) begin
               exp_q.push_back(phs[k] * 64 + b);
               ok = (dly[phs[k]][b] != NEVER) && (tmo == 0 || dly[phs[k]][b] < tmo);
               if (!ok) failed = 1'b1;
               else if (phs[k] == 0 && md != 0) exp_q.push_back(3 * 64 + b);
            end
            if (failed) begin exp_fail++; exp_mask[b] = 1'b1; end
            else exp_pass++;
         end
         exp_iter++;
      end
   endtask

   task automatic fill_const(input int v);
      for (int p = 0; p < 3; p++) for (int b = 0; b < 32; b++) dly[p][b] = v;
   endtask

   task automatic fill_rand(input int tmo);
      for (int p = 0; p < 3; p++)
         for (int b = 0; b < 32; b++)
            dly[p][b] = (tmo != 0 && $urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(0, 45));
   endtask

   function automatic int count_ev(input int p);
      int n = 0;
      foreach (ev_q[i]) if (ev_q[i].ph == p) n++;
      return n;
   endfunction

   task automatic run(input string tag, input int md, input int nb, input int tmo,
                      input int le, input int lc);
      int t, gap, last;
      mode = md[1:0]; n_buses = nb[BUS_ID_W-1:0]; timeout_cycles = tmo[TMO_W-1:0];
      loop_en = le[0]; loop_count = lc[CNT_W-1:0];
      last = (nb > N_BUSES - 1) ? N_BUSES - 1 : nb;
      model(md, nb, tmo, le, lc);
      ev_q.delete(); done_cnt = 0;
      start = 1'b1; tick(); start = 1'b0;
      chk({tag, "/busy"}, busy, 1);
      chk({tag, "/first_req"}, (md == 1) ? test_tx : test_rx, 1);
      chk({tag, "/bus0"}, bus_sel, 0);
      start = 1'b1; tick(); start = 1'b0;
      t = 0;
      while (done_cnt == 0 && t < 30000) begin tick(); t++; end
      chk({tag, "/done_in_time"}, done_cnt != 0, 1);
      repeat (3) tick();
      chk({tag, "/done_pulses"}, done_cnt, 1);
      chk({tag, "/pass_cnt"}, pass_cnt, exp_pass);
      chk({tag, "/fail_cnt"}, fail_cnt, exp_fail);
      chk({tag, "/fail_mask"}, fail_mask, exp_mask);
      chk({tag, "/iter_cnt"}, iter_cnt, exp_iter);
      chk({tag, "/bus_last"}, bus_sel, last);
      chk({tag, "/idle_busy"}, busy, 0);
      chk({tag, "/ev_count"}, ev_q.size(), exp_q.size());
      for (int i = 0; i < ev_q.size() && i < exp_q.size(); i++)
         chk({tag, "/ev"}, ev_q[i].ph * 64 + ev_q[i].bus, exp_q[i]);
      for (int i = 0; i + 1 < ev_q.size(); i++)
         if (ev_q[i].ph == 3 && ev_q[i + 1].ph == 1) begin
            gap = ev_q[i + 1].cyc - ev_q[i].cyc;
            chk({tag, "/gap"}, gap, GAP_CYCLES + 1);
         end
   endtask

   initial begin
      int t, n0, md, nb, tmo, le, lc;
      repeat (3) tick();
      chk("rst/req", {test_rx, test_tx, test_advanced, endwait_all}, 0);
      chk("rst/status", {busy, done, bus_sel}, 0);
      chk("rst/counts", {pass_cnt, fail_cnt, iter_cnt}, 0);
      chk("rst/mask", fail_mask, 0);
      rst = 1'b0; tick();

      fill_const(20);
      run("rx_tx", 2, 2, 0, 0, 0);

      fill_const(20); dly[1][1] = NEVER;
      run("tx_timeout", 3, 2, 50, 0, 0);

      fill_const(10); dly[0][0] = 29; dly[0][1] = 30;
      run("tmo_edge", 2, 1, 30, 0, 0);

      fill_const(3);
      run("clamp", 1, 31, 0, 0, 0);

      fill_const(5);
      run("loop3", 0, 0, 0, 1, 3);

      for (int r = 0; r < 8; r++) begin
         md  = int'($urandom_range(0, 3));
         nb  = int'($urandom_range(0, 3));
         tmo = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(5, 40));
         le  = int'($urandom_range(0, 1));
         lc  = int'($urandom_range(1, 2));
         spur_en = ($urandom_range(0, 1) == 1);
         fill_rand(tmo);
         run("rand", md, nb, tmo, le, lc);
      end
      spur_en = 1'b0;

      // abort inside the second bus's gap
      fill_const(20);
      mode = 2'b10; n_buses = 5'd2; timeout_cycles = '0; loop_en = 1'b0;
      ev_q.delete(); done_cnt = 0;
      start = 1'b1; tick(); start = 1'b0;
      t = 0;
      while (count_ev(3) < 2 && t < 3000) begin tick(); t++; end
      chk("abort/reach_gap", count_ev(3), 2);
      repeat (10) tick();
      abort = 1'b1; tick(); abort = 1'b0;
      chk("abort/busy", busy, 0);
      chk("abort/reqs", {test_rx, test_tx, test_advanced}, 0);
      chk("abort/pass_kept", pass_cnt, 1);
      n0 = ev_q.size();
      repeat (300) tick();
      chk("abort/no_tx", ev_q.size(), n0);
      chk("abort/no_done", done_cnt, 0);
      start = 1'b1; tick(); start = 1'b0;
      chk("abort/restart_clr", pass_cnt, 0);
      chk("abort/restart_busy", busy, 1);
      abort = 1'b1; tick(); abort = 1'b0;
      abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
      chk("abort_start/busy", busy, 0);
      tick();
      chk("abort_start/rx", test_rx, 0);

      // reset in the middle of a run
      fill_const(2);
      mode = 2'b00; n_buses = 5'd3;
      start = 1'b1; tick(); start = 1'b0;
      repeat (12) tick();
      chk("midrst/progress", pass_cnt != 0, 1);
      rst = 1'b1; tick();
      chk("midrst/counts", {pass_cnt, fail_cnt, iter_cnt}, 0);
      chk("midrst/status", {busy, test_rx, bus_sel}, 0);
      rst = 1'b0; tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
